// File: rtl/spi_slave_if.sv
// spi_slave_if: host-side bus of the SPI slave.
//
// Ports (all signals, grouped by direction through modports):
//   tx_data   [7:0]  next byte to send
//   tx_wr            one-cycle write strobe for tx_data
//   tx_ready         holding register is empty
//   rx_data   [7:0]  last complete received byte
//   rx_valid         one-cycle pulse per received byte
//   busy             synchronized SS is low
//   frame_err        one-cycle pulse on a partial-byte abort
//
// master: the host logic that feeds and drains the slave.
// slave : the spi_slave block itself.
interface spi_slave_if;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;

  modport master (
    output tx_data,
    output tx_wr,
    input  tx_ready,
    input  rx_data,
    input  rx_valid,
    input  busy,
    input  frame_err
  );

  modport slave (
    input  tx_data,
    input  tx_wr,
    output tx_ready,
    output rx_data,
    output rx_valid,
    output busy,
    output frame_err
  );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: SPI slave, all four CPOL/CPHA modes, oversampled by clk.
//
// Ports:
//   clk    in   system clock, all state changes on its rising edge
//   reset  in   synchronous active-low reset
//   cpol   in   SCLK idle level, latched at the start of each frame
//   cpha   in   0 = sample on leading edge, 1 = sample on trailing edge
//   SCLK   in   SPI clock from master (asynchronous to clk)
//   MOSI   in   SPI data from master
//   SS     in   active-low slave select
//   MISO   out  SPI data to master, high-Z while not selected
//   host   spi_slave_if.slave  tx holding register / rx byte bus
//
// SPI pins are resynchronized to clk; SCLK half-periods must be at
// least 4 clk cycles.
//
// state  | meaning
// -------+------------------------------------------------------
// IDLE   | synchronized SS high, pins ignored, MISO high-Z
// ACTIVE | synchronized SS low, shifting bytes back to back
module spi_slave (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpol,
  input  logic        cpha,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        SS,
  output wire         MISO,
  spi_slave_if.slave  host
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Synchronizers (s1, s2) plus one delayed copy (d) for edge detection.
  logic sclk_s1, sclk_s2, sclk_d;
  logic mosi_s1, mosi_s2;
  logic ss_s1,   ss_s2,   ss_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      // SCLK resets to its idle level so that no phantom edge appears
      // when the first frame starts.
      sclk_s1 <= cpol;
      sclk_s2 <= cpol;
      sclk_d  <= cpol;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
      ss_d    <= 1'b1;
    end else begin
      sclk_s1 <= SCLK;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      mosi_s1 <= MOSI;
      mosi_s2 <= mosi_s1;
      ss_s1   <= SS;
      ss_s2   <= ss_s1;
      ss_d    <= ss_s2;
    end
  end

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic [7:0] tx_hold;
  logic       tx_ready_r;
  logic [7:0] rx_data_r;
  logic       rx_valid_r;
  logic       frame_err_r;
  logic       busy_r;
  logic       cpol_l;
  logic       cpha_l;

  logic       ss_fall;
  logic       ss_rise;
  logic       sclk_edge;
  logic       lead_edge;
  logic       trail_edge;
  logic       in_frame;
  logic       sample_edge;
  logic       shift_edge;
  logic       load_now;
  logic       shift_now;
  logic       clear_now;
  logic [7:0] load_val;
  logic [7:0] rx_next;

  always_comb begin
    ss_fall     = ss_d & ~ss_s2;
    ss_rise     = ~ss_d & ss_s2;
    sclk_edge   = sclk_s2 ^ sclk_d;
    // Leading edge moves SCLK away from the latched idle level.
    lead_edge   = sclk_edge & (sclk_s2 != cpol_l);
    trail_edge  = sclk_edge & (sclk_s2 == cpol_l);
    // Edges in the same cycle as the deselect are dropped with the frame.
    in_frame    = (state == ACTIVE) & ~ss_rise;
    sample_edge = in_frame & (cpha_l ? trail_edge : lead_edge);
    shift_edge  = in_frame & (cpha_l ? lead_edge : trail_edge);
    // A shift edge with the counter at 0 starts a new byte: for cpha=0
    // that is the trailing edge after the 8th sample, for cpha=1 the
    // first leading edge of the byte. For cpha=0 the first byte must be
    // on MISO before the first edge, so it is loaded at selection.
    load_now    = ((state == IDLE) & ss_fall & ~cpha) |
                  (shift_edge & (bit_cnt == 3'd0));
    shift_now   = shift_edge & (bit_cnt != 3'd0);
    clear_now   = (state == IDLE) & ss_fall & cpha;
    load_val    = tx_ready_r ? 8'h00 : tx_hold;
    rx_next     = {rx_shift[6:0], mosi_s2};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      tx_shift    <= 8'h00;
      rx_shift    <= 8'h00;
      tx_hold     <= 8'h00;
      tx_ready_r  <= 1'b1;
      rx_data_r   <= 8'h00;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      busy_r      <= 1'b0;
      cpol_l      <= 1'b0;
      cpha_l      <= 1'b0;
    end else begin
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;

      // Host writes win over a simultaneous load: the shifter takes the
      // old held value (load_val) while the new byte stays pending.
      if (host.tx_wr) begin
        tx_hold    <= host.tx_data;
        tx_ready_r <= 1'b0;
      end else if (load_now) begin
        tx_ready_r <= 1'b1;
      end

      if (load_now) begin
        tx_shift <= load_val;
      end else if (shift_now) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end else if (clear_now) begin
        tx_shift <= 8'h00;
      end

      case (state)
        IDLE: begin
          if (ss_fall) begin
            state    <= ACTIVE;
            busy_r   <= 1'b1;
            bit_cnt  <= 3'd0;
            rx_shift <= 8'h00;
            cpol_l   <= cpol;
            cpha_l   <= cpha;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state   <= IDLE;
            busy_r  <= 1'b0;
            bit_cnt <= 3'd0;
            if (bit_cnt != 3'd0) begin
              frame_err_r <= 1'b1;
            end
          end else if (sample_edge) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data_r  <= rx_next;
              rx_valid_r <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign MISO           = (state == ACTIVE) ? tx_shift[7] : 1'bz;
  assign host.tx_ready  = tx_ready_r;
  assign host.rx_data   = rx_data_r;
  assign host.rx_valid  = rx_valid_r;
  assign host.busy      = busy_r;
  assign host.frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave. Received bytes are checked
// through an expected-byte queue drained by a monitor on rx_valid; MISO
// bytes and host-side status are checked inline by the stimulus.
// MISO is pulled up so a released line reads as 1.
module tb_spi_slave;
  localparam int H = 50;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic cpol  = 1'b0;
  logic cpha  = 1'b0;
  logic sclk  = 1'b0;
  logic mosi  = 1'b0;
  logic ss    = 1'b1;
  wire  miso;

  pullup (miso);

  spi_slave_if host_if ();

  spi_slave dut (
    .clk   (clk),
    .reset (reset),
    .cpol  (cpol),
    .cpha  (cpha),
    .SCLK  (sclk),
    .MOSI  (mosi),
    .SS    (ss),
    .MISO  (miso),
    .host  (host_if.slave)
  );

  always #5 clk = ~clk;

  int         n_cmp  = 0;
  int         n_err  = 0;
  int         rv_cnt = 0;
  int         fe_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] prev_rx = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rx_valid pops one expected byte; rx_data must not move
  // without rx_valid outside of reset.
  always @(negedge clk) begin
    if (!reset) begin
      prev_rx = host_if.rx_data;
    end else begin
      if (host_if.frame_err) fe_cnt++;
      if (host_if.rx_valid) begin
        rv_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rx_unexpected: got %0h, expected no byte", host_if.rx_data);
        end else begin
          chk("rx_byte", {24'h0, host_if.rx_data}, {24'h0, exp_q.pop_front()});
        end
      end else if (host_if.rx_data !== prev_rx) begin
        n_cmp++;
        n_err++;
        $display("FAIL rx_data_spurious: got %0h, expected %0h", host_if.rx_data, prev_rx);
      end
      prev_rx = host_if.rx_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCLK half-period; samples MISO 4 clk before and just before the
  // following edge.
  task automatic wait_half(output logic m_edge, output logic m_early);
    repeat (H - 4) @(posedge clk);
    @(negedge clk);
    m_early = miso;
    repeat (3) @(posedge clk);
    @(negedge clk);
    m_edge = miso;
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic pol, input logic pha);
    cpol = pol;
    cpha = pha;
    sclk = pol;
    tick(10);
  endtask

  task automatic host_write(input logic [7:0] d);
    host_if.tx_data = d;
    host_if.tx_wr   = 1'b1;
    tick(1);
    host_if.tx_wr   = 1'b0;
  endtask

  task automatic frame_start();
    ss = 1'b0;
    tick(H);
  endtask

  task automatic frame_end();
    ss = 1'b1;
    tick(H);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nbits,
                      output logic [7:0] mi, output logic stable);
    logic m, e, d0, d1;
    mi     = 8'h00;
    stable = 1'b1;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) begin
        mosi = mo[i];
        wait_half(m, e);
        sclk = ~cpol;
        wait_half(d0, d1);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mo[i];
        wait_half(m, e);
        sclk = cpol;
        wait_half(d0, d1);
      end
      mi[i] = m;
      if (m !== e) stable = 1'b0;
    end
  endtask

  logic [7:0] mi;
  logic       st;
  int         rv_snap;

  initial begin
    host_if.tx_data = 8'h00;
    host_if.tx_wr   = 1'b0;

    // Reset state
    tick(5);
    chk("rst_tx_ready", {31'h0, host_if.tx_ready}, 32'h1);
    chk("rst_rx_valid", {31'h0, host_if.rx_valid}, 32'h0);
    chk("rst_rx_data", {24'h0, host_if.rx_data}, 32'h0);
    chk("rst_busy", {31'h0, host_if.busy}, 32'h0);
    chk("rst_frame_err", {31'h0, host_if.frame_err}, 32'h0);
    chk("rst_miso_z", {31'h0, miso}, 32'h1);
    reset = 1'b1;
    tick(10);

    // Mode 0: send A5, receive 3C
    set_mode(1'b0, 1'b0);
    host_write(8'hA5);
    chk("m0_tx_ready_low", {31'h0, host_if.tx_ready}, 32'h0);
    exp_q.push_back(8'h3C);
    frame_start();
    chk("m0_busy", {31'h0, host_if.busy}, 32'h1);
    chk("m0_tx_ready_back", {31'h0, host_if.tx_ready}, 32'h1);
    xfer(8'h3C, 8, mi, st);
    chk("m0_miso", {24'h0, mi}, 32'hA5);
    chk("m0_stable", {31'h0, st}, 32'h1);
    frame_end();
    chk("m0_rx_data", {24'h0, host_if.rx_data}, 32'h3C);
    chk("m0_rv_cnt", rv_cnt, 1);
    chk("m0_busy_off", {31'h0, host_if.busy}, 32'h0);

    // Modes 1..3: send 81, receive 7E
    for (int md = 1; md < 4; md++) begin
      set_mode(md[1], md[0]);
      host_write(8'h81);
      exp_q.push_back(8'h7E);
      frame_start();
      xfer(8'h7E, 8, mi, st);
      chk($sformatf("m%0d_miso", md), {24'h0, mi}, 32'h81);
      chk($sformatf("m%0d_stable", md), {31'h0, st}, 32'h1);
      frame_end();
      chk($sformatf("m%0d_rx_data", md), {24'h0, host_if.rx_data}, 32'h7E);
    end
    chk("modes_rv_cnt", rv_cnt, 4);

    // Two-byte frame, second byte written during the first
    set_mode(1'b0, 1'b0);
    host_write(8'h11);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h96);
    frame_start();
    fork
      xfer(8'hC3, 8, mi, st);
      begin
        tick(3 * H);
        host_write(8'h22);
      end
    join
    chk("two_b1_miso", {24'h0, mi}, 32'h11);
    xfer(8'h96, 8, mi, st);
    chk("two_b2_miso", {24'h0, mi}, 32'h22);
    frame_end();
    chk("two_rv_cnt", rv_cnt, 6);

    // tx_wr in the same cycle as the selection load (empty holding register)
    chk("wl_ready_before", {31'h0, host_if.tx_ready}, 32'h1);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    fork
      frame_start();
      begin
        tick(2);
        host_if.tx_data = 8'h99;
        host_if.tx_wr   = 1'b1;
        tick(1);
        host_if.tx_wr   = 1'b0;
      end
    join
    chk("wl_ready_after", {31'h0, host_if.tx_ready}, 32'h0);
    xfer(8'h12, 8, mi, st);
    chk("wl_b1_miso", {24'h0, mi}, 32'h00);
    xfer(8'h34, 8, mi, st);
    chk("wl_b2_miso", {24'h0, mi}, 32'h99);
    frame_end();
    chk("wl_rv_cnt", rv_cnt, 8);

    // Abort after 5 bits
    rv_snap = rv_cnt;
    frame_start();
    xfer(8'hFF, 5, mi, st);
    chk("ab_miso_driven", {24'h0, mi}, 32'h00);
    frame_end();
    chk("ab_frame_err", fe_cnt, 1);
    chk("ab_no_rx_valid", rv_cnt, rv_snap);
    chk("ab_rx_data", {24'h0, host_if.rx_data}, 32'h34);
    chk("ab_miso_z", {31'h0, miso}, 32'h1);
    chk("ab_busy", {31'h0, host_if.busy}, 32'h0);

    // Reset mid-byte, then a clean frame
    host_write(8'h77);
    frame_start();
    xfer(8'hF0, 3, mi, st);
    reset = 1'b0;
    tick(3);
    chk("mr_tx_ready", {31'h0, host_if.tx_ready}, 32'h1);
    chk("mr_busy", {31'h0, host_if.busy}, 32'h0);
    chk("mr_rx_data", {24'h0, host_if.rx_data}, 32'h0);
    chk("mr_rx_valid", {31'h0, host_if.rx_valid}, 32'h0);
    chk("mr_frame_err", {31'h0, host_if.frame_err}, 32'h0);
    chk("mr_miso_z", {31'h0, miso}, 32'h1);
    ss   = 1'b1;
    sclk = cpol;
    tick(5);
    reset = 1'b1;
    tick(10);
    exp_q.push_back(8'h5A);
    frame_start();
    xfer(8'h5A, 8, mi, st);
    chk("mr_next_miso", {24'h0, mi}, 32'h00);
    frame_end();
    chk("mr_next_rx_data", {24'h0, host_if.rx_data}, 32'h5A);

    chk("end_rv_cnt", rv_cnt, 9);
    chk("end_fe_cnt", fe_cnt, 1);
    chk("end_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL provide these ports: clk  in  1  system clock; all state updates on its rising edge.
REQ-002 The block SHALL provide: reset  in  1  synchronous, active-low reset (reset==0 at a clk rising edge resets the block).
REQ-003 The block SHALL provide: cpol  in  1  SCLK idle level; cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 The block SHALL provide: tx_data  in  8  next byte to send; tx_wr  in  1  one-cycle write strobe for tx_data; tx_ready  out  1  high when the holding register is empty.
REQ-005 The block SHALL provide: rx_data  out  8  last complete received byte; rx_valid  out  1  one-cycle pulse per received byte.
REQ-006 The block SHALL provide: busy  out  1  synchronized SS is low; frame_err  out  1  one-cycle pulse on partial-byte abort.
REQ-007 The block SHALL provide: SCLK  in  1; MOSI  in  1; SS  in  1 (active-low select); MISO  out  1 (high-Z while synchronized SS is high).

Function
REQ-008 SCLK, MOSI and SS SHALL pass through 2-flop synchronizers, followed by one edge-detect register stage; all protocol decisions SHALL use the synchronized signals.
REQ-009 The block SHALL support SCLK half-periods of at least 4 clk cycles; shorter half-periods are unsupported.
REQ-010 cpol and cpha SHALL be latched on the synchronized SS falling edge and held constant until SS rises.
REQ-011 The leading edge SHALL be the SCLK transition away from cpol; the trailing edge SHALL be the transition back to cpol.
REQ-012 FSM states SHALL be IDLE (SS high) and ACTIVE (SS low); a 3-bit bit counter and an 8-bit tx shifter and rx shifter SHALL be used.
REQ-013 IDLE->ACTIVE SHALL occur on the synchronized SS fall, with the bit counter cleared; ACTIVE->IDLE SHALL occur on the synchronized SS rise.
REQ-014 On each sample edge, the rx shifter SHALL shift left with MOSI in the LSB, and the bit counter SHALL increment, wrapping from 7 to 0.
REQ-015 On the 8th sample edge, rx_data SHALL be loaded with the completed byte; rx_valid SHALL pulse high for exactly 1 clk in the same cycle rx_data updates.
REQ-016 MISO SHALL equal the tx shifter MSB while ACTIVE, MSB first.
REQ-017 For cpha=0, the tx shifter SHALL load at SS fall and on every 8th trailing edge; other trailing edges SHALL shift left with 0 fill.
REQ-018 For cpha=1, the tx shifter SHALL load on the first leading edge of each byte (bit counter==0); other leading edges SHALL shift left with 0 fill.
REQ-019 A load SHALL take the holding register if tx_ready==0, then set tx_ready=1; otherwise it SHALL load 0x00.
REQ-020 tx_wr SHALL write the holding register and clear tx_ready in any state; a tx_wr while tx_ready==0 SHALL overwrite the held byte.
REQ-021 If tx_wr and a load occur in the same cycle, the shifter SHALL take the old held byte (or 0x00 if empty), the new byte SHALL be stored, and tx_ready SHALL be 0.
REQ-022 Multi-byte frames with SS held low SHALL run back-to-back with no gap bits.
REQ-023 If SS rises while the bit counter is non-zero, the partial byte SHALL be discarded, rx_valid SHALL NOT pulse, frame_err SHALL pulse for 1 clk, and rx_data SHALL be unchanged.
REQ-024 SCLK and MOSI activity while SS is high SHALL be ignored.

Reset
REQ-025 On reset==0: state=IDLE, bit counter=0, shifters=0x00, holding register=0x00, rx_data=0x00, rx_valid=0, frame_err=0, tx_ready=1, busy=0, and the synchronizers SHALL load SCLK=cpol, MOSI=0, SS=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame without an rx_valid or frame_err pulse, and MISO SHALL go high-Z.

Verification
REQ-027 Mode 0, tx_wr 0xA5 then master sends 0x3C (half-period 50 clk) -> MISO bits 1,0,1,0,0,1,0,1; rx_data=0x3C; one rx_valid pulse; tx_ready back to 1.
REQ-028 Modes 1, 2 and 3, each with tx 0x81 and rx 0x7E -> correct bytes both directions in every mode; MISO stable at every master sample edge.
REQ-029 Two-byte frame with SS low throughout, tx_wr 0x11 before and 0x22 during byte 1 -> MISO 0x11 then 0x22; rx_valid pulses twice.
REQ-030 No tx_wr before the frame -> MISO sends 0x00; tx_wr in the same cycle as a load -> the byte is sent in the next byte slot.
REQ-031 SS raised after 5 bits -> frame_err pulse, no rx_valid, rx_data unchanged, MISO high-Z, busy=0.
REQ-032 reset=0 mid-byte, then a clean frame 0x5A -> all outputs at reset values; next frame rx_data=0x5A.
